// File: rtl/weight_fetch_seq.sv
// rtl/weight_fetch_seq.sv - weight ROM read sequencer with 3-entry output FIFO
// Hides registered-ROM latency and absorbs MAC backpressure via credit-limited issue.
module weight_fetch_seq #(
   parameter int numWeight    = 10,
   parameter int addressWidth = $clog2(numWeight),
   parameter int dataWidth    = 16,
   parameter int fifoDepth    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_ren,
   output logic [addressWidth-1:0] mem_radd,
   input  logic [dataWidth-1:0]    mem_wout,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [dataWidth-1:0]    out_w,
   output logic                    out_last
);

   localparam int cntWidth = $clog2(numWeight + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [cntWidth-1:0]  issue_cnt_q, issue_cnt_d;
   logic                 inflight_q, inflight_last_q;
   logic [dataWidth-1:0] fifo_data_q [0:2];
   logic [2:0]           fifo_last_q;
   logic [1:0]           rd_ptr_q, wr_ptr_q, count_q;
   logic [2:0]           credit_used;
   logic                 push, pop, issue_last;

   // Words already buffered plus the one still in the ROM pipeline must fit.
   assign credit_used = {1'b0, count_q} + {2'b00, inflight_q};
   assign mem_ren     = (state_q == RUN) && (issue_cnt_q < cntWidth'(numWeight))
                        && (credit_used < 3'(fifoDepth));
   assign mem_radd    = issue_cnt_q[addressWidth-1:0];
   assign issue_last  = (issue_cnt_q == cntWidth'(numWeight - 1));

   assign push      = inflight_q;
   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid && out_ready;
   assign out_w     = fifo_data_q[rd_ptr_q];
   assign out_last  = out_valid && fifo_last_q[rd_ptr_q];

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      case (state_q)
         IDLE: if (start) begin
            state_d     = RUN;
            issue_cnt_d = '0;
         end
         RUN: begin
            if (mem_ren) issue_cnt_d = issue_cnt_q + 1'b1;
            if (pop && out_last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         issue_cnt_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_data_q[0]  <= '0;
         fifo_data_q[1]  <= '0;
         fifo_data_q[2]  <= '0;
         fifo_last_q     <= '0;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         count_q         <= '0;
      end else begin
         state_q         <= state_d;
         issue_cnt_q     <= issue_cnt_d;
         inflight_q      <= mem_ren;
         inflight_last_q <= mem_ren && issue_last;
         if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_wout;
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
         end
         if (pop) rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
         if (push && !pop)      count_q <= count_q + 2'd1;
         else if (pop && !push) count_q <= count_q - 2'd1;
      end
   end

   assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_q == 2'd3)));

endmodule

// File: doc/weight_fetch_seq.md
Name: weight_fetch_seq

Overview:
- Read-side sequencer for a per-neuron weight ROM.
- On a start pulse, it issues `numWeight` sequential reads to the ROM. The ROM has a registered read port (`ren`/`radd` in; `wout` valid one cycle later).
- It buffers the returned words in a small FIFO and streams them to the neuron MAC over a valid/ready interface, tagging the final beat.
- It hides the ROM read latency and absorbs MAC backpressure without losing, duplicating or reordering weights.

Parameters:
- numWeight, 10, number of weights per neuron; legal values are 2 or more.
- addressWidth, $clog2(numWeight), ROM address width.
- dataWidth, 16, weight word width.
- fifoDepth, 3, output buffer entries; fixed at 3 (minimum for full throughput with no out_ready→mem_ren combinational path).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to fetch one full weight set.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final beat is accepted.
- mem_ren  output  1  ROM read enable.
- mem_radd  output  addressWidth  ROM read address.
- mem_wout  input  dataWidth  ROM read data, valid the cycle after mem_ren.
- out_valid  output  1  weight beat available.
- out_ready  input  1  MAC accepts a beat.
- out_w  output  dataWidth  weight word at the FIFO head.
- out_last  output  1  head beat is index numWeight-1.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - Outputs busy, done, mem_ren, out_valid and out_last are 0.
  - mem_radd, out_w and the issue counter are 0.
  - FIFO is empty and the inflight flag is clear.
- States are IDLE, RUN and DONE.
  - IDLE → RUN when start=1: issue counter cleared, busy=1 next cycle.
  - RUN → DONE on the edge where out_valid&out_ready&out_last=1.
  - DONE → IDLE unconditionally after one cycle; done=1 and busy=0 during DONE.
  - start is accepted only in IDLE. It is ignored in RUN and in DONE.
- Issue rule, in RUN:
  - mem_ren=1 iff issue_cnt < numWeight AND (fifo_count + inflight) < fifoDepth.
  - mem_radd=issue_cnt, driven combinationally from the counter.
  - issue_cnt increments on each edge with mem_ren=1.
  - mem_ren is never asserted outside RUN.
- Capture:
  - inflight is set on each edge with mem_ren=1 and cleared otherwise.
  - When inflight=1, mem_wout is pushed into the FIFO at the next edge, together with last = (index == numWeight-1).
- Output:
  - out_valid = FIFO not empty.
  - out_w and out_last come from the head entry and are held stable while out_valid=1 and out_ready=0.
  - The head is popped on out_valid & out_ready.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- Credit accounting guarantees the FIFO never overflows. A push into a full FIFO is a design error; it is covered by an assertion.
- Latency with start in cycle 0 and out_ready held high:
  - mem_ren is 1 in cycles 1..10 (radd 0..9).
  - out_valid is 1 in cycles 3..12.
  - out_last is 1 in cycle 12.
  - done is 1 in cycle 13. Throughput is 1 beat/cycle.
- Reset asserted mid-run:
  - All state is cleared immediately.
  - No done pulse is produced.
  - Partial data is discarded.
  - The next start fetches from address 0.

Test Plan:
- Reset values: assert rst_n=0 for 3 cycles with random inputs → every output is 0 and mem_ren never pulses.
- Full streaming:
  - Stimulus: ROM model holds mem[0]=16'h181B … mem[9]=16'hC756; start in cycle 0; out_ready=1.
  - Required response: out_w is 181B..C756 in cycles 3..12; out_last is set only in cycle 12; done is high only in cycle 13; exactly 10 mem_ren pulses.
- Backpressure:
  - Stimulus: out_ready=0 in cycles 3..9.
  - Required response: out_w holds 16'h181B. At most 3 words are fetched (fifo_count + inflight ≤ 3). mem_ren stays 0 until out_ready returns. After resuming, the stream is 0..9 in order with no duplicates.
- Random out_ready, 50% duty, over 5 back-to-back runs: each run delivers exactly 10 beats in address order; mem_radd is never above 9; there is one done pulse per run; start pulses issued while busy are ignored.
- Reset mid-run: drop rst_n after the 4th accepted beat, then release it and pulse start → outputs clear immediately, no done pulse, and the fresh stream begins with 16'h181B.
- Start in the DONE cycle is ignored; start in the following IDLE cycle produces a second full run with identical timing.
